// File: rtl/rollback_issue_buffer_pkg.sv
// Shared decode-bundle types for the 3-way front end: packet layout, NOP encoding,
// superscalar width and the pop-count -> way-mask helper used by ID/EX as well.
package rollback_issue_buffer_pkg;

  localparam int WAYS = 3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } if_id_packet_t;

  localparam if_id_packet_t NOP_PACKET = '{inst: NOP, pc: 32'h0, valid: 1'b0};

  function automatic logic [WAYS-1:0] thermometer(input logic [1:0] pop);
    case (pop)
      2'd0:    thermometer = 3'b000;
      2'd1:    thermometer = 3'b001;
      2'd2:    thermometer = 3'b011;
      default: thermometer = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/rollback_issue_buffer_mem.sv
// Circular entry storage: 3 write ports at tail+0..2, 3 async read ports at head+0..2.
// Reads are zero-latency; writes land on the next edge. No backpressure of its own.
module issue_buffer_mem
  import rollback_issue_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic [PTR_W-1:0]    wr_base,
  input  logic [WAYS-1:0]     wr_en,
  input  if_id_packet_t       wr_pkt_0,
  input  if_id_packet_t       wr_pkt_1,
  input  if_id_packet_t       wr_pkt_2,
  input  logic [PTR_W-1:0]    rd_base,
  input  logic [WAYS-1:0]     rd_clr,
  output if_id_packet_t       rd_pkt_0,
  output if_id_packet_t       rd_pkt_1,
  output if_id_packet_t       rd_pkt_2,
  output logic [WAYS-1:0]     rd_vld
);

  if_id_packet_t    data [DEPTH];
  logic [DEPTH-1:0] vld;
  if_id_packet_t    wr_pkt [WAYS];
  logic [PTR_W-1:0] ra [WAYS];

  assign wr_pkt[0] = wr_pkt_0;
  assign wr_pkt[1] = wr_pkt_1;
  assign wr_pkt[2] = wr_pkt_2;

  always_ff @(posedge clock) begin
    for (int i = 0; i < WAYS; i++) begin
      if (wr_en[i]) data[wr_base + PTR_W'(i)] <= wr_pkt[i];
    end
  end

  // Head and tail windows never overlap while pushing, so clear-then-set order is safe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld <= '0;
    end else if (clear) begin
      vld <= '0;
    end else begin
      for (int i = 0; i < WAYS; i++) begin
        if (rd_clr[i]) vld[rd_base + PTR_W'(i)] <= 1'b0;
      end
      for (int i = 0; i < WAYS; i++) begin
        if (wr_en[i]) vld[wr_base + PTR_W'(i)] <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      ra[i]     = rd_base + PTR_W'(i);
      rd_vld[i] = vld[ra[i]];
    end
  end

  assign rd_pkt_0 = data[ra[0]];
  assign rd_pkt_1 = data[ra[1]];
  assign rd_pkt_2 = data[ra[2]];

endmodule

// File: rtl/rollback_issue_buffer.sv
// IF->ID issue buffer: presents the 3 oldest entries combinationally (0-cycle latency),
// retires only non-rolled-back leading ways; if_ready drops when fewer than 3 slots are free.
module rollback_issue_buffer
  import rollback_issue_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                squash,
  input  logic                stall,
  input  if_id_packet_t       if_packet_0,
  input  if_id_packet_t       if_packet_1,
  input  if_id_packet_t       if_packet_2,
  input  logic [2:0]          if_valid,
  output logic                if_ready,
  input  logic [1:0]          rollback,
  output if_id_packet_t       out_packet_0,
  output if_id_packet_t       out_packet_1,
  output if_id_packet_t       out_packet_2,
  output logic [2:0]          out_valid,
  output logic [2:0]          dispatched,
  output logic [PTR_W:0]      count
);

  localparam logic [PTR_W:0] CNT_WAYS  = (PTR_W+1)'(WAYS);
  localparam logic [PTR_W:0] CNT_RDY   = (PTR_W+1)'(DEPTH - WAYS);
  localparam logic [PTR_W:0] CNT_DEPTH = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count_q;
  logic [1:0]       presented, avail, pop, push;
  logic [WAYS-1:0]  wr_en, rd_vld;
  if_id_packet_t    rd_pkt_0, rd_pkt_1, rd_pkt_2;

  function automatic if_id_packet_t present(input logic en, input if_id_packet_t p, input logic v);
    if_id_packet_t r;
    r       = p;
    r.valid = v;
    return en ? r : NOP_PACKET;
  endfunction

  assign presented  = (count_q >= CNT_WAYS) ? 2'd3 : count_q[1:0];
  assign avail      = 2'd3 - rollback;
  assign pop        = stall ? 2'd0 : ((presented < avail) ? presented : avail);
  assign dispatched = thermometer(pop);
  assign out_valid  = thermometer(presented);

  // Driven only from the registered count so hazard logic never loops back into fetch.
  assign if_ready   = (count_q <= CNT_RDY);
  assign push       = if_ready ? 2'($countones(if_valid)) : 2'd0;
  assign wr_en      = (if_ready && !squash) ? if_valid : 3'b000;
  assign count      = count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (squash) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + PTR_W'(pop);
      tail    <= tail + PTR_W'(push);
      count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  issue_buffer_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clock    (clock),
    .reset    (reset),
    .clear    (squash),
    .wr_base  (tail),
    .wr_en    (wr_en),
    .wr_pkt_0 (if_packet_0),
    .wr_pkt_1 (if_packet_1),
    .wr_pkt_2 (if_packet_2),
    .rd_base  (head),
    .rd_clr   (dispatched),
    .rd_pkt_0 (rd_pkt_0),
    .rd_pkt_1 (rd_pkt_1),
    .rd_pkt_2 (rd_pkt_2),
    .rd_vld   (rd_vld)
  );

  assign out_packet_0 = present(out_valid[0], rd_pkt_0, rd_vld[0]);
  assign out_packet_1 = present(out_valid[1], rd_pkt_1, rd_vld[1]);
  assign out_packet_2 = present(out_valid[2], rd_pkt_2, rd_vld[2]);

  a_if_valid_contig: assert property (@(posedge clock) disable iff (!reset)
    (if_valid == 3'b000 || if_valid == 3'b001 || if_valid == 3'b011 || if_valid == 3'b111));

  a_count_bound: assert property (@(posedge clock) disable iff (!reset) (count_q <= CNT_DEPTH));

endmodule

// File: tb/tb_rollback_issue_buffer.sv
// Directed table-driven check of the issue buffer plus hand-written reset sequences.
module tb_rollback_issue_buffer;
  import rollback_issue_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          squash = 1'b0;
  logic          stall = 1'b0;
  logic [2:0]    if_valid = 3'b000;
  logic [1:0]    rollback = 2'd0;
  if_id_packet_t if_packet_0, if_packet_1, if_packet_2;
  if_id_packet_t out_packet_0, out_packet_1, out_packet_2;
  logic          if_ready;
  logic [2:0]    out_valid, dispatched;
  logic [PTR_W:0] count;

  always #5 clock = ~clock;

  rollback_issue_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .squash       (squash),
    .stall        (stall),
    .if_packet_0  (if_packet_0),
    .if_packet_1  (if_packet_1),
    .if_packet_2  (if_packet_2),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .rollback     (rollback),
    .out_packet_0 (out_packet_0),
    .out_packet_1 (out_packet_1),
    .out_packet_2 (out_packet_2),
    .out_valid    (out_valid),
    .dispatched   (dispatched),
    .count        (count)
  );

  typedef struct {
    logic       sq;
    logic       st;
    logic [2:0] ifv;
    logic [1:0] rb;
    int         e_cnt;
    logic       e_rdy;
    logic [2:0] e_ov;
    logic [2:0] e_disp;
    int         e_h;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   nseq  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic sq, input logic st, input logic [2:0] ifv, input logic [1:0] rb,
                     input int e_cnt, input logic e_rdy, input logic [2:0] e_ov,
                     input logic [2:0] e_disp, input int e_h);
    vec_t v;
    v = '{sq: sq, st: st, ifv: ifv, rb: rb, e_cnt: e_cnt, e_rdy: e_rdy,
          e_ov: e_ov, e_disp: e_disp, e_h: e_h};
    vecs.push_back(v);
  endtask

  function automatic if_id_packet_t mk(input int seq, input logic v);
    if_id_packet_t p;
    p.inst  = 32'h1000 + 32'(seq);
    p.pc    = 32'(seq * 4);
    p.valid = v;
    return p;
  endfunction

  task automatic drive_fetch(input logic [2:0] ifv);
    if_valid    = ifv;
    if_packet_0 = mk(nseq + 0, ifv[0]);
    if_packet_1 = mk(nseq + 1, ifv[1]);
    if_packet_2 = mk(nseq + 2, ifv[2]);
  endtask

  task automatic chk_ways(input string tag, input logic [2:0] ov, input int h);
    if_id_packet_t p [3];
    p[0] = out_packet_0;
    p[1] = out_packet_1;
    p[2] = out_packet_2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_w%0d_inst", tag, k), int'(p[k].inst), ov[k] ? (32'h1000 + h + k) : int'(NOP));
      chk($sformatf("%s_w%0d_vld", tag, k), int'(p[k].valid), int'(ov[k]));
    end
  endtask

  initial begin
    //   sq st ifv     rb  cnt rdy ov      disp    head
    add(0, 0, 3'b111, 0,  0, 1, 3'b000, 3'b000,  0);
    add(0, 0, 3'b111, 0,  3, 1, 3'b111, 3'b111,  0);
    add(0, 0, 3'b000, 0,  3, 1, 3'b111, 3'b111,  3);
    add(0, 0, 3'b000, 2,  0, 1, 3'b000, 3'b000,  6);
    add(0, 0, 3'b111, 0,  0, 1, 3'b000, 3'b000,  6);
    add(0, 0, 3'b001, 2,  3, 1, 3'b111, 3'b001,  6);
    add(0, 0, 3'b000, 0,  3, 1, 3'b111, 3'b111,  7);
    add(0, 0, 3'b111, 3,  0, 1, 3'b000, 3'b000, 10);
    add(0, 0, 3'b111, 3,  3, 1, 3'b111, 3'b000, 10);
    add(0, 0, 3'b111, 3,  6, 0, 3'b111, 3'b000, 10);
    add(0, 0, 3'b000, 3,  6, 0, 3'b111, 3'b000, 10);
    add(0, 0, 3'b000, 0,  6, 0, 3'b111, 3'b111, 10);
    add(0, 0, 3'b000, 2,  3, 1, 3'b111, 3'b001, 13);
    add(0, 0, 3'b111, 3,  2, 1, 3'b011, 3'b000, 14);
    add(0, 0, 3'b000, 0,  5, 1, 3'b111, 3'b111, 14);
    add(0, 1, 3'b001, 0,  2, 1, 3'b011, 3'b000, 17);
    add(0, 1, 3'b000, 0,  3, 1, 3'b111, 3'b000, 17);
    add(0, 0, 3'b000, 2,  3, 1, 3'b111, 3'b001, 17);
    add(0, 0, 3'b000, 2,  2, 1, 3'b011, 3'b001, 18);
    add(0, 0, 3'b000, 1,  1, 1, 3'b001, 3'b001, 19);
    add(0, 0, 3'b011, 3,  0, 1, 3'b000, 3'b000, 20);
    add(0, 0, 3'b111, 1,  2, 1, 3'b011, 3'b011, 20);
    add(0, 0, 3'b111, 0,  3, 1, 3'b111, 3'b111, 22);
    add(0, 0, 3'b111, 2,  3, 1, 3'b111, 3'b001, 25);
    add(1, 0, 3'b111, 0,  5, 1, 3'b111, 3'b111, 26);
    add(0, 0, 3'b000, 0,  0, 1, 3'b000, 3'b000,  0);
    add(0, 0, 3'b111, 0,  0, 1, 3'b000, 3'b000,  0);
    add(0, 0, 3'b000, 0,  3, 1, 3'b111, 3'b111, 31);

    drive_fetch(3'b000);
    #12;
    chk("rst_count", int'(count), 0);
    chk("rst_if_ready", int'(if_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_dispatched", int'(dispatched), 0);
    chk_ways("rst", 3'b000, 0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clock);
      squash   = vecs[i].sq;
      stall    = vecs[i].st;
      rollback = vecs[i].rb;
      drive_fetch(vecs[i].ifv);
      #1;
      chk($sformatf("r%0d_count", i), int'(count), vecs[i].e_cnt);
      chk($sformatf("r%0d_if_ready", i), int'(if_ready), int'(vecs[i].e_rdy));
      chk($sformatf("r%0d_out_valid", i), int'(out_valid), int'(vecs[i].e_ov));
      chk($sformatf("r%0d_dispatched", i), int'(dispatched), int'(vecs[i].e_disp));
      chk_ways($sformatf("r%0d", i), vecs[i].e_ov, vecs[i].e_h);
      if (!vecs[i].sq && vecs[i].e_rdy) nseq += $countones(vecs[i].ifv);
    end

    // Asynchronous reset in the middle of a cycle while fetch keeps pushing.
    @(negedge clock);
    squash   = 1'b0;
    stall    = 1'b0;
    rollback = 2'd0;
    drive_fetch(3'b111);
    @(posedge clock);
    #2;
    chk("arst_pre_count", int'(count), 3);
    chk("arst_pre_head", int'(out_packet_0.inst), 32'h1000 + nseq);
    nseq += 3;
    reset = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_if_ready", int'(if_ready), 1);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_dispatched", int'(dispatched), 0);
    chk_ways("arst", 3'b000, 0);
    @(negedge clock);
    reset = 1'b1;
    drive_fetch(3'b000);
    @(negedge clock);
    #1;
    chk("arst_post_count", int'(count), 0);
    chk("arst_post_out_valid", int'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
